sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO with independent data width and depth. Provides registered full/empty flags, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. A FWFT parameter selects first-word-fall-through or standard registered-read mode. It is the general-purpose buffer between same-clock producer/consumer blocks and replaces the fixed-width FIFO.

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/sync_fifo_ram.sv | 36 +++
 rtl/sync_fifo_flags.sv | 132 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_flags buffer family.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEPTH          = 1 << DEF_ADDR_WIDTH;
  localparam int unsigned DEF_AF_THRESH  = DEPTH - 2;
  localparam int unsigned DEF_AE_THRESH  = 2;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, async or registered read.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register holds its value between reads; only the read port is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = FWFT ? mem[raddr] : rdata_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered flags, thresholds, sticky errors and flush.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned      NWORDS  = 1 << ADDR_WIDTH;
  localparam int unsigned      CW      = clog2(NWORDS + 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(NWORDS);
  localparam logic [CW-1:0]    AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0]    AE_C    = CW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  ov_q, ov_d, un_q, un_d;
  logic                  dv_q, dv_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rdata;

  // Flush suppresses both accepts so neither memory nor read register moves.
  always_comb begin
    wr_acc = wr_en & ~full_q  & ~flush;
    rd_acc = rd_en & ~empty_q & ~flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Flags come from next-state count so they line up with count itself.
  always_comb begin
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    ov_d    = clr_err ? 1'b0 : (ov_q | (wr_en & full_q));
    un_d    = clr_err ? 1'b0 : (un_q | (rd_en & empty_q));
    dv_d    = rd_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_THRESH == 0);
      ae_q     <= 1'b1;
      ov_q     <= 1'b0;
      un_q     <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ov_q     <= ov_d;
      un_q     <= un_d;
      dv_q     <= dv_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FWFT       (FWFT)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // In FWFT mode the stale head word is masked so dout reads 0 while empty.
  assign dout_valid   = FWFT ? ~empty_q : dv_q;
  assign dout         = (FWFT && empty_q) ? '0 : rdata;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ov_q;
  assign underflow    = un_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard and FWFT instances share stimulus.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n, flush, clr_err, wr_en, rd_en;
  logic [7:0] din;

  logic [7:0] dout0, dout1;
  logic [3:0] count0, count1;
  logic       dv0, full0, empty0, af0, ae0, ov0, un0;
  logic       dv1, full1, empty1, af1, ae1, ov1, un1;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(dout0), .dout_valid(dv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ov0), .underflow(un0));

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(dout1), .dout_valid(dv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ov1), .underflow(un1));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of words plus the sticky bits and the standard read register.
  logic [7:0] mq[$];
  logic       m_ov, m_un, m_dv;
  logic [7:0] m_dout;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ov = 1'b0; m_un = 1'b0; m_dv = 1'b0; m_dout = 8'h00;
  endfunction

  function automatic void model_step(input bit w, input bit r, input bit f, input bit c, input logic [7:0] d);
    bit was_full, was_empty;
    was_full  = (mq.size() == 8);
    was_empty = (mq.size() == 0);
    if (c) begin m_ov = 1'b0; m_un = 1'b0; end
    else begin
      if (w && was_full)  m_ov = 1'b1;
      if (r && was_empty) m_un = 1'b1;
    end
    m_dv = 1'b0;
    if (f) mq.delete();
    else begin
      if (r && !was_empty) begin m_dout = mq.pop_front(); m_dv = 1'b1; end
      if (w && !was_full) mq.push_back(d);
    end
  endfunction

  function automatic void check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, " count0"}, 32'(count0), 32'(n));
    chk({tag, " count1"}, 32'(count1), 32'(n));
    chk({tag, " full0"},  32'(full0),  32'(n == 8));
    chk({tag, " full1"},  32'(full1),  32'(n == 8));
    chk({tag, " empty0"}, 32'(empty0), 32'(n == 0));
    chk({tag, " empty1"}, 32'(empty1), 32'(n == 0));
    chk({tag, " af0"},    32'(af0),    32'(n >= 6));
    chk({tag, " ae0"},    32'(ae0),    32'(n <= 2));
    chk({tag, " af1"},    32'(af1),    32'(n >= 6));
    chk({tag, " ae1"},    32'(ae1),    32'(n <= 2));
    chk({tag, " ov0"},    32'(ov0),    32'(m_ov));
    chk({tag, " un0"},    32'(un0),    32'(m_un));
    chk({tag, " ov1"},    32'(ov1),    32'(m_ov));
    chk({tag, " un1"},    32'(un1),    32'(m_un));
    chk({tag, " dv0"},    32'(dv0),    32'(m_dv));
    chk({tag, " dout0"},  32'(dout0),  32'(m_dout));
    chk({tag, " dv1"},    32'(dv1),    32'(n != 0));
    chk({tag, " dout1"},  32'(dout1),  (n != 0) ? 32'(mq[0]) : 32'h0);
  endfunction

  // Drive on the falling edge, advance the model on the rising edge, sample 1 ns later.
  task automatic cycle(input bit w, input bit r, input bit f, input bit c, input logic [7:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; flush = f; clr_err = c; din = d;
    @(posedge clk);
    model_step(w, r, f, c, d);
    #1;
  endtask

  typedef struct {
    bit w, r, f, c;
    logic [7:0] d;
    int cnt;
    bit full, empty, af, ae, ov, un, dv;
    logic [7:0] dout;
  } vec_t;

  function automatic vec_t mk(bit w, bit r, bit f, bit c, logic [7:0] d, int cnt,
                              bit fl, bit em, bit af, bit ae, bit ov, bit un, bit dv, logic [7:0] dout);
    vec_t v;
    v.w = w; v.r = r; v.f = f; v.c = c; v.d = d; v.cnt = cnt;
    v.full = fl; v.empty = em; v.af = af; v.ae = ae; v.ov = ov; v.un = un; v.dv = dv; v.dout = dout;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    //           w r f c din    cnt fl em af ae ov un dv dout
    tbl[0]  = mk(1,0,0,0,8'h10, 1,  0, 0, 0, 1, 0, 0, 0, 8'h00);
    tbl[1]  = mk(1,0,0,0,8'h11, 2,  0, 0, 0, 1, 0, 0, 0, 8'h00);
    tbl[2]  = mk(1,0,0,0,8'h12, 3,  0, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[3]  = mk(1,0,0,0,8'h13, 4,  0, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[4]  = mk(1,0,0,0,8'h14, 5,  0, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[5]  = mk(1,0,0,0,8'h15, 6,  0, 0, 1, 0, 0, 0, 0, 8'h00);
    tbl[6]  = mk(1,0,0,0,8'h16, 7,  0, 0, 1, 0, 0, 0, 0, 8'h00);
    tbl[7]  = mk(1,0,0,0,8'h17, 8,  1, 0, 1, 0, 0, 0, 0, 8'h00);
    tbl[8]  = mk(1,0,0,0,8'h99, 8,  1, 0, 1, 0, 1, 0, 0, 8'h00);
    tbl[9]  = mk(0,1,0,0,8'h00, 7,  0, 0, 1, 0, 1, 0, 1, 8'h10);
    tbl[10] = mk(0,1,0,0,8'h00, 6,  0, 0, 1, 0, 1, 0, 1, 8'h11);
    tbl[11] = mk(0,1,0,0,8'h00, 5,  0, 0, 0, 0, 1, 0, 1, 8'h12);
    tbl[12] = mk(0,1,0,0,8'h00, 4,  0, 0, 0, 0, 1, 0, 1, 8'h13);
    tbl[13] = mk(0,1,0,0,8'h00, 3,  0, 0, 0, 0, 1, 0, 1, 8'h14);
    tbl[14] = mk(0,1,0,0,8'h00, 2,  0, 0, 0, 1, 1, 0, 1, 8'h15);
    tbl[15] = mk(0,1,0,0,8'h00, 1,  0, 0, 0, 1, 1, 0, 1, 8'h16);
    tbl[16] = mk(0,1,0,0,8'h00, 0,  0, 1, 0, 1, 1, 0, 1, 8'h17);
    tbl[17] = mk(0,1,0,0,8'h00, 0,  0, 1, 0, 1, 1, 1, 0, 8'h17);
    tbl[18] = mk(0,0,0,1,8'h00, 0,  0, 1, 0, 1, 0, 0, 0, 8'h17);

    rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Fill, overflow, drain, underflow, clear.
    foreach (tbl[i]) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].f, tbl[i].c, tbl[i].d);
      chk($sformatf("tbl%0d count", i), 32'(count0), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d full", i),  32'(full0),  32'(tbl[i].full));
      chk($sformatf("tbl%0d empty", i), 32'(empty0), 32'(tbl[i].empty));
      chk($sformatf("tbl%0d af", i),    32'(af0),    32'(tbl[i].af));
      chk($sformatf("tbl%0d ae", i),    32'(ae0),    32'(tbl[i].ae));
      chk($sformatf("tbl%0d ov", i),    32'(ov0),    32'(tbl[i].ov));
      chk($sformatf("tbl%0d un", i),    32'(un0),    32'(tbl[i].un));
      chk($sformatf("tbl%0d dv", i),    32'(dv0),    32'(tbl[i].dv));
      chk($sformatf("tbl%0d dout", i),  32'(dout0),  32'(tbl[i].dout));
      chk($sformatf("tbl%0d count1", i), 32'(count1), 32'(tbl[i].cnt));
    end

    // Simultaneous read/write at count 4; pointers wrap past 7.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 8'h20 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0, 0, 8'h30 + 8'(i));
      chk("rw count", 32'(count0), 32'd4);
      chk("rw dout", 32'(dout0), (i < 4) ? 32'(8'h20 + 8'(i)) : 32'(8'h30 + 8'(i - 4)));
      check_all("rw");
    end

    // Read and write at full: read wins, write rejected.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 8'h50 + 8'(i));
    chk("full before rw", 32'(full0), 32'd1);
    cycle(1, 1, 0, 0, 8'hBB);
    chk("full rw count", 32'(count0), 32'd7);
    chk("full rw ov", 32'(ov0), 32'd1);
    chk("full rw dout", 32'(dout0), 32'h36);
    check_all("fullrw");

    // FWFT: single word to an empty FIFO falls through on the next cycle.
    cycle(0, 0, 1, 1, 8'h00);
    check_all("flush1");
    cycle(1, 0, 0, 0, 8'hA5);
    chk("fwft dout", 32'(dout1), 32'hA5);
    chk("fwft dv", 32'(dv1), 32'd1);
    cycle(0, 1, 0, 0, 8'h00);
    chk("fwft pop dv", 32'(dv1), 32'd0);
    chk("fwft pop empty", 32'(empty1), 32'd1);
    check_all("fwft");

    // Flush beats a simultaneous write; pointers restart at 0.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 8'h40 + 8'(i));
    chk("pre-flush count", 32'(count0), 32'd5);
    cycle(1, 0, 1, 0, 8'hEE);
    chk("flush count", 32'(count0), 32'd0);
    chk("flush empty", 32'(empty0), 32'd1);
    chk("flush dout held", 32'(dout0), 32'hA5);
    cycle(1, 0, 0, 0, 8'h55);
    cycle(0, 1, 0, 0, 8'h00);
    chk("post-flush dout", 32'(dout0), 32'h55);
    check_all("flush2");

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 8'h60 + 8'(i));
    cycle(0, 1, 0, 0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async rst count", 32'(count0), 32'd0);
    chk("async rst dout", 32'(dout0), 32'd0);
    check_all("async rst");
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    rst_n = 1'b1;

    // Randomised traffic with alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      int wb;
      bit w, r, f, c;
      wb = ((i / 200) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < wb);
      r = ($urandom_range(0, 99) < (100 - wb));
      f = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 31) == 0);
      cycle(w, r, f, c, 8'($urandom));
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
